// File: rtl/mlaccel_pkg.sv
// Shared types and constants for the sequencer-memory responder.
package mlaccel_pkg;

  localparam int unsigned SMEM_ADDR_W = 16;
  localparam int unsigned SMEM_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSeqRd,
    StSeqRsp,
    StHostRd,
    StHostRsp,
    StHostWr
  } smem_state_t;

  // Addresses count 16-bit units; RAM words are 32 bits.
  function automatic logic [SMEM_ADDR_W-2:0] smem_word_idx(input logic [SMEM_ADDR_W-1:0] addr);
    return addr[SMEM_ADDR_W-1:1];
  endfunction

endpackage

// File: rtl/mlaccel_smem_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read data held between reads.
module mlaccel_smem_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mlaccel_smem_responder.sv
// Code-RAM owner arbitrating sequencer fetches and host loads round-robin.
// Optional stored even parity with read check: define MLACCEL_SMEM_PARITY_EN.
module mlaccel_smem_responder
  import mlaccel_pkg::*;
#(
  parameter int unsigned DEPTH          = 4096,
  parameter bit          LAST_GRANT_RST = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   smem_valid,
  output logic                   smem_ready,
  input  logic [SMEM_ADDR_W-1:0] smem_addr,
  output logic [SMEM_DATA_W-1:0] smem_data,
  input  logic                   host_valid,
  input  logic                   host_write,
  input  logic [SMEM_ADDR_W-1:0] host_addr,
  input  logic [SMEM_DATA_W-1:0] host_wdata,
  output logic                   host_ready,
  output logic [SMEM_DATA_W-1:0] host_rdata,
  output logic                   addr_err,
  output logic                   parity_err
);

  localparam int unsigned AddrW = $clog2(DEPTH);
`ifdef MLACCEL_SMEM_PARITY_EN
  localparam int unsigned RamW = SMEM_DATA_W + 1;
`else
  localparam int unsigned RamW = SMEM_DATA_W;
`endif

  smem_state_t            state_d, state_q;
  logic                   last_grant_d, last_grant_q;  // 1 = host won the last tie
  logic [AddrW-1:0]       idx_d, idx_q;
  logic                   oor_d, oor_q;
  logic [SMEM_DATA_W-1:0] wdata_d, wdata_q;
  logic                   smem_ready_d, smem_ready_q;
  logic                   host_ready_d, host_ready_q;
  logic [SMEM_DATA_W-1:0] smem_data_d, smem_data_q;
  logic [SMEM_DATA_W-1:0] host_rdata_d, host_rdata_q;
  logic                   addr_err_d, addr_err_q;

  logic                   seq_go, host_go;
  logic [SMEM_ADDR_W-1:0] grant_addr;
  logic [SMEM_ADDR_W-2:0] grant_idx;
  logic                   ram_en, ram_we;
  logic [RamW-1:0]        ram_wdata, ram_rdata;
  logic [SMEM_DATA_W-1:0] rd_word;

  assign rd_word = oor_q ? '0 : ram_rdata[SMEM_DATA_W-1:0];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    oor_d        = oor_q;
    wdata_d      = wdata_q;
    smem_ready_d = 1'b0;
    host_ready_d = 1'b0;
    smem_data_d  = (state_q == StSeqRsp) ? rd_word : smem_data_q;
    host_rdata_d = (state_q == StHostRsp) ? rd_word : host_rdata_q;
    addr_err_d   = addr_err_q;
    seq_go       = smem_valid && (!host_valid || last_grant_q);
    host_go      = host_valid && !seq_go;
    grant_addr   = seq_go ? smem_addr : host_addr;
    grant_idx    = smem_word_idx(grant_addr);
    unique case (state_q)
      StIdle: begin
        if (seq_go || host_go) begin
          idx_d      = grant_idx[AddrW-1:0];
          oor_d      = 32'(grant_idx) >= DEPTH;
          wdata_d    = host_wdata;
          addr_err_d = addr_err_q | grant_addr[0] | oor_d;
          // The pointer only moves on a genuine tie.
          if (smem_valid && host_valid) last_grant_d = host_go;
          if (seq_go) begin
            state_d = StSeqRd;
          end else if (host_write) begin
            state_d      = StHostWr;
            host_ready_d = 1'b1;
          end else begin
            state_d = StHostRd;
          end
        end
      end
      StSeqRd: begin
        if (smem_valid) begin
          state_d      = StSeqRsp;
          smem_ready_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StHostRd: begin
        if (host_valid) begin
          state_d      = StHostRsp;
          host_ready_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= LAST_GRANT_RST;
      idx_q        <= '0;
      oor_q        <= 1'b0;
      wdata_q      <= '0;
      smem_ready_q <= 1'b0;
      host_ready_q <= 1'b0;
      smem_data_q  <= '0;
      host_rdata_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      oor_q        <= oor_d;
      wdata_q      <= wdata_d;
      smem_ready_q <= smem_ready_d;
      host_ready_q <= host_ready_d;
      smem_data_q  <= smem_data_d;
      host_rdata_q <= host_rdata_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign ram_en = !reset && ((state_q == StSeqRd) || (state_q == StHostRd) ||
                             ((state_q == StHostWr) && !oor_q));
  assign ram_we = (state_q == StHostWr);

`ifdef MLACCEL_SMEM_PARITY_EN
  logic parity_err_d, parity_err_q;

  assign ram_wdata = {^wdata_q, wdata_q};

  always_comb begin
    parity_err_d = parity_err_q;
    if (((state_q == StSeqRsp) || (state_q == StHostRsp)) && !oor_q && (^ram_rdata)) begin
      parity_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign ram_wdata  = wdata_q;
  assign parity_err = 1'b0;
`endif

  mlaccel_smem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RamW)
  ) u_ram (
    .clock   (clock),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Read data is visible combinationally during the strobe, then held.
  assign smem_ready = smem_ready_q;
  assign host_ready = host_ready_q;
  assign smem_data  = (state_q == StSeqRsp) ? rd_word : smem_data_q;
  assign host_rdata = (state_q == StHostRsp) ? rd_word : host_rdata_q;
  assign addr_err   = addr_err_q;

endmodule
